weight_burst_ram: RTL and testbench
===================================

// Module: weight_burst_ram
// PURPOSE
//   Parametrised SNN synaptic-weight store: P lanes of WBITS-bit weights per row, DEPTH rows.
//   Adds over the plain single-read weight RAM: a masked host write port, and a burst read
//   engine with valid/ready output handshake and a 2-entry skid FIFO for backpressure.
//   Sits between the weight loader (write side) and the neuron-array accumulator (read side).
// PARAMETERS
//   DEPTH      512                rows in memory
//   ADDRWID    $clog2(DEPTH)      row address width; also burst-length field width
//   P          64                 lanes (weights) per row
//   WBITS      8                  bits per weight
//   WIDTH      WBITS*P            row width
//   INIT_RAMP  1                  1: row i initialised to {P{i[WBITS-1:0]}}; 0: all zero (sim init only)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   wen        in   1        write strobe
//   waddr      in   ADDRWID  write row
//   wdata      in   WIDTH    write data
//   wmask      in   P        per-lane enable; lane k = bits [k*WBITS +: WBITS]
//   req_valid  in   1        burst request valid
//   req_ready  out  1        burst request accept (=1 when engine IDLE)
//   req_addr   in   ADDRWID  first row of burst
//   req_len    in   ADDRWID  beats-1 (0 -> 1 beat, DEPTH-1 -> DEPTH beats)
//   rvalid     out  1        read beat valid
//   rready     in   1        consumer accept
//   rdata      out  WIDTH    read beat data
//   rlast      out  1        final beat of burst, qualified by rvalid
//   busy       out  1        engine not IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset: rvalid=0, rlast=0, rdata=0, FIFO count=0, state=IDLE (req_ready=1), busy=0.
//     Memory contents NOT cleared by reset. Reset mid-burst aborts burst, drops FIFO beats.
//   Write: on edge with wen=1, lanes with wmask[k]=1 of mem[waddr] updated; others kept. 1-cycle.
//   Request: accepted on edge with req_valid&req_ready; latch ptr=req_addr, remaining=req_len;
//     state IDLE->BURST. Request ignored in BURST (req_ready=0).
//   Issue (BURST): issue read of mem[ptr] when FIFO has room after this edge's pop:
//     issue = BURST & (count<2 | (rvalid&rready)). Read data, with rlast=(remaining==0),
//     is pushed into FIFO on the same edge. ptr=ptr+1, wraps DEPTH-1 -> 0
//     (explicit compare, DEPTH need not be power of 2). remaining decrements.
//     Issue with remaining==0 -> state BURST->IDLE on that edge.
//   Latency: first beat rvalid=1 one edge after accepting edge. rready held 1 -> 1 beat/cycle,
//     no bubbles; next request acceptable on cycle after last issue (beats overlap in FIFO).
//   Handshake: beat transfers on edge with rvalid&rready. rvalid/rdata/rlast stable while
//     rvalid&!rready. rdata holds last value when rvalid=0 (not zeroed).
//   Read-during-write same row, same edge: read returns OLD row (read-first); write still lands.
//   Simultaneous push+pop with count==2: allowed, count stays 2, order preserved.
//   busy = (state!=IDLE) | (count!=0).
// STRUCTURE
//   Shared header snn_params.vh: default P, WBITS, weight-memory DEPTH (shared with neuron array).
//   Sub-module weight_skid_fifo (2-entry, WIDTH+1 bits {rlast,data}, push/pop/count, flush on reset).
//   Top: memory array + masked write + 2-state burst FSM + address/length counters.
// TESTING
//   1. Post-reset single beat: req_addr=5,len=0 -> rvalid one edge after accept,
//      rdata={64{8'h05}}, rlast=1; busy drops after pop.
//   2. Masked write: wen,waddr=3,wdata=all 8'hAA,wmask=0x1 -> burst read row 3 gives lane0=8'hAA,
//      lanes1..63=8'h03.
//   3. Wrap burst: addr=510,len=3, rready=1 -> rows 510,511,0,1 on 4 consecutive cycles, rlast on 4th.
//   4. Backpressure: len=7, rready toggles 1,0,0,1... -> all 8 beats in order, none lost/duplicated,
//      data stable while stalled, FIFO count never >2.
//   5. Read-during-write: burst on row 9 while wen to row 9 same edge -> beat shows old data;
//      next burst shows new data.
//   6. Reset mid-burst: len=15, assert rst_n=0 after 4 beats -> rvalid=0 immediately, req_ready=1;
//      subsequent burst returns correct rows.

Source files
------------

// File: rtl/weight_burst_ram_pkg.sv
// Shared SNN weight-store defaults (lane count, weight width, row depth) and the
// burst-engine state type used by weight_burst_ram.
package weight_burst_ram_pkg;

  localparam int SNN_DEPTH = 512;
  localparam int SNN_P     = 64;
  localparam int SNN_WBITS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid FIFO holding {rlast, data} beats between the weight array and
// the consumer. Entry e0 is always the head; it keeps its last value when empty.
module weight_skid_fifo #(
  parameter int DW = 513
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] e0_q;
  logic [DW-1:0] e1_q;
  logic [1:0]    count_q;

  // The caller only pops a non-empty FIFO and only pushes a full one together with a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_q <= din;
          else                 e1_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) e0_q <= e1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_q <= din;
          end else begin
            e0_q <= e1_q;
            e1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0_q;
  assign count = count_q;

endmodule

// File: rtl/weight_burst_ram.sv
// SNN synaptic-weight store: masked host write port plus a burst read engine that
// streams rows through a 2-entry skid FIFO under a valid/ready output handshake.
module weight_burst_ram
  import weight_burst_ram_pkg::*;
#(
  parameter int DEPTH     = SNN_DEPTH,
  parameter int P         = SNN_P,
  parameter int WBITS     = SNN_WBITS,
  parameter int ADDRWID   = $clog2(DEPTH),
  parameter int WIDTH     = WBITS * P,
  parameter bit INIT_RAMP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wen,
  input  logic [ADDRWID-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [P-1:0]       wmask,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDRWID-1:0] req_addr,
  input  logic [ADDRWID-1:0] req_len,
  output logic               rvalid,
  input  logic               rready,
  output logic [WIDTH-1:0]   rdata,
  output logic               rlast,
  output logic               busy
);

  // Handshakes: a request moves on an edge with req_valid & req_ready, a beat on an
  // edge with rvalid & rready; rvalid/rdata/rlast never change while rvalid & !rready.

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   lane_bits;
  logic [WIDTH-1:0]   ramp_w;
  logic [WIDTH-1:0]   ramp_r;
  logic [WIDTH-1:0]   rd_row;

  burst_state_e       state_q, state_d;
  logic [ADDRWID-1:0] ptr_q, ptr_d;
  logic [ADDRWID-1:0] rem_q, rem_d;
  logic               issue;
  logic               pop;
  logic [1:0]         fifo_cnt;
  logic [WIDTH:0]     fifo_head;

  for (genvar k = 0; k < P; k++) begin : g_lane
    assign lane_bits[k*WBITS +: WBITS] = {WBITS{wmask[k]}};
  end

  // Rows are stored XOR'ed with their ramp pattern, so a zero power-up state reads
  // back as the ramp image without needing a reset or init loop on the array.
  assign ramp_w = INIT_RAMP ? {P{WBITS'(waddr)}} : '0;
  assign ramp_r = INIT_RAMP ? {P{WBITS'(ptr_q)}} : '0;

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= (mem[waddr] & ~lane_bits) | ((wdata ^ ramp_w) & lane_bits);
  end

  // Combinational read of the pre-edge row gives read-first behaviour on a same-row write.
  assign rd_row = mem[ptr_q] ^ ramp_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BURST;
          ptr_d   = req_addr;
          rem_d   = req_len;
        end
      end
      ST_BURST: begin
        if (fifo_cnt != 2'd2 || pop) begin
          issue = 1'b1;
          ptr_d = (ptr_q == ADDRWID'(DEPTH - 1)) ? '0 : ptr_q + ADDRWID'(1);
          if (rem_q == '0) state_d = ST_IDLE;
          else             rem_d   = rem_q - ADDRWID'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  weight_skid_fifo #(
    .DW(WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (issue),
    .din  ({rem_q == '0, rd_row}),
    .pop  (pop),
    .dout (fifo_head),
    .count(fifo_cnt)
  );

  assign rvalid    = (fifo_cnt != 2'd0);
  assign pop       = rvalid & rready;
  assign rdata     = fifo_head[WIDTH-1:0];
  assign rlast     = rvalid & fifo_head[WIDTH];
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE) | (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_weight_burst_ram.sv
// Directed plus randomized bench for weight_burst_ram: an array model of the weight
// store produces the expected beat queue for each burst.
module tb_weight_burst_ram;

  localparam int DEPTH = 512;
  localparam int P     = 64;
  localparam int WBITS = 8;
  localparam int AW    = 9;
  localparam int W     = WBITS * P;

  logic          clk;
  logic          rst_n;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [P-1:0]  wmask;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic          rvalid;
  logic          rready;
  logic [W-1:0]  rdata;
  logic          rlast;
  logic          busy;

  weight_burst_ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wen      (wen),
    .waddr    (waddr),
    .wdata    (wdata),
    .wmask    (wmask),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_len  (req_len),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata),
    .rlast    (rlast),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard state
  logic [W-1:0] ref_mem [DEPTH];
  logic [W:0]   exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc;
  int           beats_got;
  int           last_cyc;
  bit           prev_stall;
  logic [W:0]   prev_beat;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_write(input int addr, input logic [W-1:0] d, input logic [P-1:0] m);
    for (int k = 0; k < P; k++)
      if (m[k]) ref_mem[addr][k*WBITS +: WBITS] = d[k*WBITS +: WBITS];
  endtask

  // one clock: consume/check a beat if the handshake fires on the coming edge
  task automatic tick();
    if (prev_stall) begin
      chk("stall_rvalid", rvalid, 1'b1);
      chk("stall_hold", {rlast, rdata}, prev_beat);
    end
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", rvalid, 1'b0);
      end else begin
        chk("beat", {rlast, rdata}, exp_q.pop_front());
        beats_got++;
        if (rlast) last_cyc = cyc;
      end
    end
    prev_stall = rvalid && !rready;
    prev_beat  = {rlast, rdata};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_write(input int addr, input logic [W-1:0] d, input logic [P-1:0] m);
    wen   = 1'b1;
    waddr = AW'(addr);
    wdata = d;
    wmask = m;
    tick();
    wen = 1'b0;
    model_write(addr, d, m);
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  // mode: 0 rready held high, 1 pattern 1,0,0,..., 2 random.
  // abort_after >= 0 resets the DUT once that many beats have been taken.
  // rdw=1 writes rdw_data to row addr on the edge that reads it.
  task automatic run_burst(input int addr, input int len, input int mode,
                           input int abort_after, input bit rdw, input logic [W-1:0] rdw_data);
    int         first_v;
    logic [W-1:0] last_data;
    chk("req_ready_idle", req_ready, 1'b1);
    prev_stall = 1'b0;
    for (int b = 0; b <= len; b++)
      exp_q.push_back({b == len, ref_mem[(addr + b) % DEPTH]});
    last_data = ref_mem[(addr + len) % DEPTH];
    req_addr  = AW'(addr);
    req_len   = AW'(len);
    req_valid = 1'b1;
    rready    = pick_ready(mode, 0);
    tick();
    req_valid = 1'b0;
    cyc       = 0;
    beats_got = 0;
    last_cyc  = -1;
    first_v   = -1;
    chk("req_ready_after_accept", req_ready, 1'b0);
    chk("rvalid_after_accept", rvalid, 1'b0);
    if (rdw) begin
      wen   = 1'b1;
      waddr = AW'(addr);
      wdata = rdw_data;
      wmask = '1;
    end
    while (exp_q.size() != 0 && cyc < 400) begin
      if (first_v < 0 && rvalid) first_v = cyc;
      if (abort_after >= 0 && beats_got == abort_after) break;
      rready = pick_ready(mode, cyc);
      tick();
      wen = 1'b0;
    end
    chk("first_beat_latency", first_v, 1);
    if (rdw) model_write(addr, rdw_data, '1);
    if (abort_after >= 0) begin
      rst_n = 1'b0;
      #1;
      chk("abort_rvalid", rvalid, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_busy", busy, 1'b0);
      exp_q.delete();
      prev_stall = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      chk("beats_received", beats_got, len + 1);
      if (mode == 0) chk("no_bubbles_last_cycle", last_cyc, len + 1);
      chk("rvalid_after_drain", rvalid, 1'b0);
      chk("busy_after_drain", busy, 1'b0);
      chk("rdata_hold", rdata, last_data);
    end
    rready = 1'b0;
  endtask

  // directed and random stimulus
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {P{WBITS'(i)}};
    rst_n     = 1'b0;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    wmask     = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rready    = 1'b0;
    prev_stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_rlast", rlast, 1'b0);
    chk("reset_rdata", rdata, '0);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);

    // single beat from the ramp image
    run_burst(5, 0, 0, -1, 1'b0, '0);
    // masked write touches lane 0 only
    do_write(3, {P{8'hAA}}, 64'h1);
    run_burst(3, 0, 0, -1, 1'b0, '0);
    // address wrap across the last row
    run_burst(510, 3, 0, -1, 1'b0, '0);
    // backpressure pattern
    run_burst(40, 7, 1, -1, 1'b0, '0);
    // read-during-write returns the old row, next burst sees the new one
    run_burst(9, 0, 0, -1, 1'b1, rand_row());
    run_burst(9, 0, 0, -1, 1'b0, '0);
    // reset mid-burst, then a clean burst over the same rows
    run_burst(100, 15, 0, 4, 1'b0, '0);
    run_burst(100, 15, 0, -1, 1'b0, '0);

    // randomized writes and bursts
    repeat (8) begin
      repeat (3) do_write($urandom_range(0, DEPTH - 1), rand_row(), {$urandom, $urandom});
      run_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), $urandom_range(0, 2),
                -1, 1'b0, '0);
    end
    run_burst(DEPTH - 2, 5, 2, -1, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
